ec_data_resp: RTL

//  - Data-side SRAM-like bus handshake engine for the EC (exception/commit) stage, directly upstream of ec_wb_seg.
//  - Issues one data request per memory instruction in EC.
//  - Tracks addr_ok/data_ok and buffers the response until the stage advances; produces ec_data_ok/ec_data_rdata for ec_wb_seg.
//  - Raises a stall request while the response is pending.
//  - Responses belonging to flushed (refresh) instructions are drained and discarded.

---
 rtl/cpu_defs.sv | 16 +
 rtl/ec_data_resp.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Shared core definitions: EC data-response FSM state codes and access size codes.
package cpu_defs;

  typedef enum logic [2:0] {
    EDR_IDLE = 3'd0,
    EDR_REQ  = 3'd1,
    EDR_WAIT = 3'd2,
    EDR_DONE = 3'd3,
    EDR_KILL = 3'd4
  } edr_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/ec_data_resp.sv
// EC-stage data bus handshake: issues one request per memory instruction, buffers the
// response until the stage advances, and drains responses of flushed instructions.
module ec_data_resp
  import cpu_defs::*;
#(
  parameter int unsigned DISC_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        refresh,
  input  logic        ec_memreq,
  input  logic        ec_wr,
  input  logic [1:0]  ec_size,
  input  logic [31:0] ec_addr,
  input  logic [3:0]  ec_wstrb,
  input  logic [31:0] ec_wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        ec_data_ok,
  output logic [31:0] ec_data_rdata,
  output logic        ec_stall_req
);

  localparam logic [DISC_W-1:0] DiscMax = '1;

  edr_state_e        state_q, state_d, cur;
  logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              own_ok, drop, issue, disc_inc, resp_ok;

  assign data_wr    = ec_wr;
  assign data_size  = ec_size;
  assign data_addr  = ec_addr;
  assign data_wstrb = ec_wstrb;
  assign data_wdata = ec_wdata;

  always_comb begin
    // While in reset the outputs look like IDLE with nothing outstanding.
    cur           = resetn ? state_q : EDR_IDLE;
    own_ok        = data_data_ok & (disc_cnt_q == '0);
    drop          = data_data_ok & (disc_cnt_q != '0);
    issue         = resetn & ec_memreq & ~refresh & (disc_cnt_q != DiscMax);
    state_d       = cur;
    rbuf_d        = rbuf_q;
    disc_inc      = 1'b0;
    data_req      = 1'b0;
    resp_ok       = 1'b0;
    ec_data_rdata = '0;

    unique case (cur)
      EDR_IDLE: begin
        data_req = issue;
        if (issue) state_d = data_addr_ok ? EDR_WAIT : EDR_REQ;
      end
      EDR_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          state_d  = refresh ? EDR_IDLE : EDR_WAIT;
          disc_inc = refresh;
        end else if (refresh) begin
          state_d = EDR_KILL;
        end
      end
      EDR_KILL: begin
        // An issued request is never withdrawn; its response becomes an orphan.
        data_req = 1'b1;
        if (data_addr_ok) begin
          state_d  = EDR_IDLE;
          disc_inc = 1'b1;
        end
      end
      EDR_WAIT: begin
        resp_ok       = own_ok;
        ec_data_rdata = own_ok ? data_rdata : '0;
        if (refresh) begin
          state_d  = EDR_IDLE;
          disc_inc = ~own_ok;
        end else if (own_ok) begin
          if (stall) begin
            state_d = EDR_DONE;
            rbuf_d  = data_rdata;
          end else begin
            state_d = EDR_IDLE;
          end
        end
      end
      EDR_DONE: begin
        resp_ok       = 1'b1;
        ec_data_rdata = rbuf_q;
        if (~stall | refresh) state_d = EDR_IDLE;
      end
      default: state_d = EDR_IDLE;
    endcase

    ec_data_ok   = resp_ok;
    ec_stall_req = ec_memreq & ~resp_ok & (cur != EDR_KILL);

    unique case ({disc_inc, drop})
      2'b10:   disc_cnt_d = disc_cnt_q + DISC_W'(1);
      2'b01:   disc_cnt_d = disc_cnt_q - DISC_W'(1);
      default: disc_cnt_d = disc_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= EDR_IDLE;
      disc_cnt_q <= '0;
      rbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      disc_cnt_q <= disc_cnt_d;
      rbuf_q     <= rbuf_d;
    end
  end

endmodule
